// File: rtl/b07_point_loader.sv
// b07_point_loader: writer-side companion to the b07 line-point counter.
// Accepts 16 coordinate bytes (x0, y0 .. x7, y7) over a valid/ready handshake,
// stores them in a 16x8 point memory with a combinational read port, and
// counts the points that satisfy 3x + y == 2 (mod 256) while loading.
module b07_point_loader (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] punti_attesi
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_X = 3'd1,
    S_LOAD_Y = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t     state;
  state_t     stateNext;
  logic [3:0] mar;
  logic [3:0] marNext;
  logic [7:0] x;
  logic [7:0] xNext;
  logic [7:0] y;
  logic [7:0] yNext;
  logic [3:0] cont;
  logic [3:0] contNext;
  logic [7:0] punti;
  logic [7:0] puntiNext;
  logic       memWe;
  logic [7:0] lineSum;
  logic [7:0] mem [16];

  // Left-hand side of the line equation; 8-bit adds wrap naturally mod 256.
  assign lineSum = x + x + x + y;

  // Read port is purely combinational: a write becomes visible after its edge.
  assign rd_data      = mem[rd_addr];
  assign punti_attesi = punti;

  // Next-state and register-update decode; status outputs depend on state only.
  always_comb begin
    stateNext = state;
    marNext   = mar;
    xNext     = x;
    yNext     = y;
    contNext  = cont;
    puntiNext = punti;
    memWe     = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          marNext   = 4'h0;
          contNext  = 4'h0;
          stateNext = S_LOAD_X;
        end
      end
      S_LOAD_X: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          memWe     = 1'b1;
          xNext     = in_data;
          marNext   = mar + 4'h1;
          stateNext = S_LOAD_Y;
        end
      end
      S_LOAD_Y: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          memWe     = 1'b1;
          yNext     = in_data;
          stateNext = S_CHECK;
        end
      end
      S_CHECK: begin
        busy = 1'b1;
        if (lineSum == 8'h02) begin
          contNext = cont + 4'h1;
        end
        if (mar == 4'hF) begin
          puntiNext = {4'h0, contNext};
          stateNext = S_DONE;
        end else begin
          marNext   = mar + 4'h1;
          stateNext = S_LOAD_X;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          marNext   = 4'h0;
          contNext  = 4'h0;
          stateNext = S_LOAD_X;
        end
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase
  end

  // State, datapath registers and point memory; reset clears everything at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      mar   <= 4'h0;
      x     <= 8'h00;
      y     <= 8'h00;
      cont  <= 4'h0;
      punti <= 8'h00;
      for (int i = 0; i < 16; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      state <= stateNext;
      mar   <= marNext;
      x     <= xNext;
      y     <= yNext;
      cont  <= contNext;
      punti <= puntiNext;
      if (memWe) begin
        mem[mar] <= in_data;
      end
    end
  end

endmodule
